// File: rtl/ec_datapath.sv
// Accumulator CPU datapath: PC, IR, A, MDR and a synchronous-read RAM with a program-load port.
// Executes the per-cycle control word from the control unit and returns opcode/status.
module ec_datapath #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [1:0]        Asel,
  input  logic [DATA_W-1:0] Input,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic [2:0]        IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] Aout,
  output logic [ADDR_W-1:0] PCout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] alu;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    ram_addr = Meminst ? ir_q[ADDR_W-1:0] : pc_q;
    alu      = Sub ? (a_q + ~mdr_q + DATA_W'(1)) : (a_q + mdr_q);

    pc_d = pc_q;
    if (PCload) pc_d = JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);

    ir_d = IRload ? mdr_q : ir_q;

    a_d = a_q;
    if (Aload) begin
      unique case (Asel)
        2'b00:   a_d = alu;
        2'b01:   a_d = Input;
        2'b10:   a_d = mdr_q;
        default: a_d = '0;
      endcase
    end

    // The read sees the pre-edge RAM contents, giving read-before-write on a shared address.
    mdr_d = ram[ram_addr];

    // Program load wins over the CPU store; stores are blocked while in reset.
    wr_en   = LoadEn | (MemWr & Reset);
    wr_addr = LoadEn ? LoadAddr : ram_addr;
    wr_data = LoadEn ? LoadData : a_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      mdr_q <= mdr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  assign IR    = ir_q[DATA_W-1:ADDR_W];
  assign Aeq0  = (a_q == '0);
  assign Apos  = (a_q != '0) && !a_q[DATA_W-1];
  assign Aout  = a_q;
  assign PCout = pc_q;

endmodule
